// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipelined MIPS execute stage.
package pipe_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // ALU op codes; ealuc[3] is only significant for the shift-right pair.
  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  // Multiply/divide op codes.
  localparam logic [1:0] MDOP_MULT  = 2'b00;
  localparam logic [1:0] MDOP_MULTU = 2'b01;
  localparam logic [1:0] MDOP_DIV   = 2'b10;
  localparam logic [1:0] MDOP_DIVU  = 2'b11;

  typedef enum logic {StIdle, StBusy} md_state_e;

endpackage

// File: rtl/pipe_muldiv.sv
// Iterative multiply/divide unit: one shift-add or restoring-subtract step per cycle,
// sign fix-up on completion, HI/LO result registers.
module pipe_muldiv
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  md_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] acc_q;   // upper product half / partial remainder
  logic [XLEN-1:0] opa_q;   // multiplier / dividend, shifts into quotient
  logic [XLEN-1:0] opb_q;   // multiplicand / divisor magnitude
  logic            div_q, neg_q, rneg_q, dz_q;
  logic [XLEN-1:0] hi_q, lo_q;

  logic            signed_op, is_div, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic            div_fits;
  logic [XLEN-1:0] acc_nx, opa_nx;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix;

  assign signed_op = (op == MDOP_MULT) || (op == MDOP_DIV);
  assign is_div    = (op == MDOP_DIV) || (op == MDOP_DIVU);
  assign sa        = signed_op & a[XLEN-1];
  assign sb        = signed_op & b[XLEN-1];
  // Unsigned negate also gives the right magnitude for the most negative value.
  assign a_mag     = sa ? -a : a;
  assign b_mag     = sb ? -b : b;

  // One iteration step plus the sign-corrected results of the final step.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (opa_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q, opa_q[XLEN-1]};
    div_fits  = div_shift >= {1'b0, opb_q};
    if (div_q) begin
      acc_nx = div_fits ? (div_shift[XLEN-1:0] - opb_q) : div_shift[XLEN-1:0];
      opa_nx = {opa_q[XLEN-2:0], div_fits};
    end else begin
      acc_nx = mul_sum[XLEN:1];
      opa_nx = {mul_sum[0], opa_q[XLEN-1:1]};
    end
    prod     = {acc_nx, opa_nx};
    prod_fix = neg_q ? -prod : prod;
    // Divide by zero yields all-ones quotient regardless of sign.
    quot_fix = dz_q ? '1 : (neg_q ? -opa_nx : opa_nx);
    rem_fix  = rneg_q ? -acc_nx : acc_nx;
  end

  // Control FSM, datapath registers and HI/LO write-back.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StBusy;
            cnt_q   <= '0;
            acc_q   <= '0;
            opa_q   <= a_mag;
            opb_q   <= b_mag;
            div_q   <= is_div;
            neg_q   <= sa ^ sb;
            rneg_q  <= sa;
            dz_q    <= is_div && (b == '0);
          end
        end
        StBusy: begin
          acc_q <= acc_nx;
          opa_q <= opa_nx;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(XLEN - 1)) begin
            state_q <= StIdle;
            if (div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              hi_q <= prod_fix[2*XLEN-1:XLEN];
              lo_q <= prod_fix[XLEN-1:0];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StBusy);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/pipe_exe_stage.sv
// Execute stage: ALU, jal link path, HI/LO readout and mul/div interlock.
module pipe_exe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [3:0]      ealuc,
  input  logic            ealuimm,
  input  logic            eshift,
  input  logic            ejal,
  input  logic [XLEN-1:0] ea,
  input  logic [XLEN-1:0] eb_in,
  input  logic [XLEN-1:0] eimm,
  input  logic [XLEN-1:0] epc4,
  input  logic            emdstart,
  input  logic [1:0]      emdop,
  input  logic            emfhi,
  input  logic            emflo,
  input  logic            ewreg_in,
  input  logic            em2reg_in,
  input  logic            ewmem_in,
  input  logic [4:0]      ern_in,
  output logic [XLEN-1:0] ealu,
  output logic [XLEN-1:0] eb,
  output logic [4:0]      ern,
  output logic            ewreg,
  output logic            em2reg,
  output logic            ewmem,
  output logic            stall,
  output logic            md_busy
);

  logic [XLEN-1:0] a_op, b_op, alu_res, hi, lo;
  logic [3:0]      op_key;
  logic [4:0]      shamt;

  assign a_op  = eshift ? {{(XLEN-5){1'b0}}, eimm[10:6]} : ea;
  assign b_op  = ealuimm ? eimm : eb_in;
  assign shamt = a_op[4:0];
  // Bit 3 only distinguishes srl from sra; fold it away for every other op.
  assign op_key = (ealuc[2:0] == 3'b111) ? ealuc : {1'b0, ealuc[2:0]};

  // ALU result; all arithmetic wraps.
  always_comb begin
    alu_res = '0;
    case (op_key)
      ALUC_ADD: alu_res = a_op + b_op;
      ALUC_SUB: alu_res = a_op - b_op;
      ALUC_AND: alu_res = a_op & b_op;
      ALUC_OR:  alu_res = a_op | b_op;
      ALUC_XOR: alu_res = a_op ^ b_op;
      ALUC_LUI: alu_res = b_op << 16;
      ALUC_SLL: alu_res = b_op << shamt;
      ALUC_SRL: alu_res = b_op >> shamt;
      ALUC_SRA: alu_res = $unsigned($signed(b_op) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  // Result select: link address, then HI, then LO, then ALU.
  always_comb begin
    if (ejal)       ealu = epc4 + XLEN'(4);
    else if (emfhi) ealu = hi;
    else if (emflo) ealu = lo;
    else            ealu = alu_res;
  end

  pipe_muldiv #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clock (clock),
    .resetn(resetn),
    .start (emdstart),
    .op    (emdop),
    .a     (ea),
    .b     (eb_in),
    .hi    (hi),
    .lo    (lo),
    .busy  (md_busy)
  );

  // HI/LO consumers and a second mul/div wait for the unit; the stalled slot becomes a bubble.
  assign stall  = md_busy & (emfhi | emflo | emdstart);
  assign eb     = eb_in;
  assign ern    = ern_in;
  assign ewreg  = ewreg_in & ~stall;
  assign em2reg = em2reg_in & ~stall;
  assign ewmem  = ewmem_in & ~stall;

endmodule
